// File: rtl/vmcoffee_pkg.sv
// Shared types and widths for the coffee brew controller.
// State encoding is fixed so downstream debug tools can decode the state bus.
package vmcoffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRIND = 3'd1,
        ST_HEAT  = 3'd2,
        ST_PUMP  = 3'd3,
        ST_DONE  = 3'd4
    } brew_state_t;

    localparam int WATER_W    = 5;
    localparam int WATER_FULL = 31;
    localparam int BEAN_W     = 4;
    localparam int TMR_W      = 8;

endpackage

// File: rtl/brew_timer.sv
// Phase down counter: loads N-1 on phase entry, counts down and holds at zero.
// The owning FSM leaves a phase on the edge where zero is high.
module brew_timer
    import vmcoffee_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/coffee_brew_ctrl.sv
// Brew sequencer behind the vending FSM: grind -> heat -> pump -> done,
// with water/bean inventory tracking and one-cycle DONE/DROP/FAULT pulses.
module coffee_brew_ctrl
    import vmcoffee_pkg::*;
#(
    parameter int GRIND_CYC     = 8,
    parameter int HEAT_CYC      = 16,
    parameter int PUMP_CYC      = 12,
    parameter int WATER_PER_CUP = 2,
    parameter int BEAN_MAX      = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               COFFEE,
    input  logic               REFILL_W,
    input  logic               REFILL_B,
    output logic [WATER_W-1:0] WATER,
    output logic               BEANS,
    output logic               GRIND,
    output logic               HEAT,
    output logic               PUMP,
    output logic               BUSY,
    output logic               DONE,
    output logic               DROP,
    output logic               FAULT
);

    localparam logic [WATER_W-1:0] WATER_CUP = WATER_W'(WATER_PER_CUP);
    localparam logic [WATER_W-1:0] WATER_TOP = WATER_W'(WATER_FULL);
    localparam logic [BEAN_W-1:0]  BEAN_TOP  = BEAN_W'(BEAN_MAX);
    localparam logic [TMR_W-1:0]   GRIND_LD  = TMR_W'(GRIND_CYC - 1);
    localparam logic [TMR_W-1:0]   HEAT_LD   = TMR_W'(HEAT_CYC - 1);
    localparam logic [TMR_W-1:0]   PUMP_LD   = TMR_W'(PUMP_CYC - 1);

    brew_state_t       state;
    logic [BEAN_W-1:0] bean_cnt;
    logic              stock_ok;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    function automatic logic [WATER_W-1:0] water_after_cup(input logic [WATER_W-1:0] lvl);
        return (lvl >= WATER_CUP) ? lvl - WATER_CUP : '0;
    endfunction

    function automatic logic [BEAN_W-1:0] beans_after_cup(input logic [BEAN_W-1:0] cnt);
        return (cnt != '0) ? cnt - 1'b1 : '0;
    endfunction

    assign stock_ok = (WATER >= WATER_CUP) && (bean_cnt != '0);
    assign BEANS    = (bean_cnt != '0);

    // Timer reload points coincide with every phase entry.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GRIND_LD;
        case (state)
            ST_IDLE: begin
                tmr_load = COFFEE && stock_ok;
                tmr_val  = GRIND_LD;
            end
            ST_GRIND: begin
                tmr_load = tmr_zero;
                tmr_val  = HEAT_LD;
            end
            ST_HEAT: begin
                tmr_load = tmr_zero;
                tmr_val  = PUMP_LD;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = GRIND_LD;
            end
        endcase
    end

    brew_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            GRIND    <= 1'b0;
            HEAT     <= 1'b0;
            PUMP     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DROP     <= 1'b0;
            FAULT    <= 1'b0;
            WATER    <= WATER_TOP;
            bean_cnt <= BEAN_TOP;
        end else begin
            DONE  <= 1'b0;
            FAULT <= 1'b0;
            DROP  <= COFFEE && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    // Order is judged on pre-refill stock; refill lands on the same edge.
                    if (COFFEE) begin
                        if (stock_ok) begin
                            state <= ST_GRIND;
                            GRIND <= 1'b1;
                            BUSY  <= 1'b1;
                        end else begin
                            FAULT <= 1'b1;
                        end
                    end
                    if (REFILL_W) WATER    <= WATER_TOP;
                    if (REFILL_B) bean_cnt <= BEAN_TOP;
                end
                ST_GRIND: begin
                    if (tmr_zero) begin
                        state    <= ST_HEAT;
                        GRIND    <= 1'b0;
                        HEAT     <= 1'b1;
                        bean_cnt <= beans_after_cup(bean_cnt);
                    end
                end
                ST_HEAT: begin
                    if (tmr_zero) begin
                        state <= ST_PUMP;
                        HEAT  <= 1'b0;
                        PUMP  <= 1'b1;
                    end
                end
                ST_PUMP: begin
                    if (tmr_zero) begin
                        state <= ST_DONE;
                        PUMP  <= 1'b0;
                        DONE  <= 1'b1;
                        WATER <= water_after_cup(WATER);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    GRIND <= 1'b0;
                    HEAT  <= 1'b0;
                    PUMP  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// Randomized bench for coffee_brew_ctrl against a cycle-count model of a brew.
// A brew is tracked as an index k since acceptance; outputs follow from k ranges.
module tb_coffee_brew_ctrl;

    localparam int G    = 8;
    localparam int H    = 16;
    localparam int P    = 12;
    localparam int WPC  = 2;
    localparam int BMAX = 15;
    localparam int T    = G + H + P;

    logic       clk = 1'b0;
    logic       rst;
    logic       COFFEE;
    logic       REFILL_W;
    logic       REFILL_B;
    logic [4:0] WATER;
    logic       BEANS;
    logic       GRIND;
    logic       HEAT;
    logic       PUMP;
    logic       BUSY;
    logic       DONE;
    logic       DROP;
    logic       FAULT;

    coffee_brew_ctrl #(
        .GRIND_CYC     (G),
        .HEAT_CYC      (H),
        .PUMP_CYC      (P),
        .WATER_PER_CUP (WPC),
        .BEAN_MAX      (BMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .COFFEE   (COFFEE),
        .REFILL_W (REFILL_W),
        .REFILL_B (REFILL_B),
        .WATER    (WATER),
        .BEANS    (BEANS),
        .GRIND    (GRIND),
        .HEAT     (HEAT),
        .PUMP     (PUMP),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DROP     (DROP),
        .FAULT    (FAULT)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit m_active;
    int m_k;
    int m_water;
    int m_beans;
    bit m_drop;
    bit m_fault;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit rw, input bit rb);
        if (r) begin
            m_active = 0;
            m_k      = 0;
            m_water  = 31;
            m_beans  = BMAX;
            m_drop   = 0;
            m_fault  = 0;
        end else begin
            m_drop  = 0;
            m_fault = 0;
            if (!m_active) begin
                if (c) begin
                    if (m_water >= WPC && m_beans >= 1) begin
                        m_active = 1;
                        m_k      = 1;
                    end else begin
                        m_fault = 1;
                    end
                end
                if (rw) m_water = 31;
                if (rb) m_beans = BMAX;
            end else begin
                if (c) m_drop = 1;
                m_k++;
                if (m_k == G + 1) m_beans = m_beans - 1;
                if (m_k == T + 1) m_water = m_water - WPC;
                if (m_k > T + 1) begin
                    m_active = 0;
                    m_k      = 0;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit rw, input bit rb);
        rst      = r;
        COFFEE   = c;
        REFILL_W = rw;
        REFILL_B = rb;
        @(posedge clk);
        cyc++;
        model_edge(r, c, rw, rb);
        #1;
        check("GRIND", int'(GRIND), int'(m_active && m_k >= 1 && m_k <= G));
        check("HEAT",  int'(HEAT),  int'(m_active && m_k > G && m_k <= G + H));
        check("PUMP",  int'(PUMP),  int'(m_active && m_k > G + H && m_k <= T));
        check("DONE",  int'(DONE),  int'(m_active && m_k == T + 1));
        check("BUSY",  int'(BUSY),  int'(m_active));
        check("DROP",  int'(DROP),  int'(m_drop));
        check("FAULT", int'(FAULT), int'(m_fault));
        check("WATER", int'(WATER), m_water);
        check("BEANS", int'(BEANS), int'(m_beans != 0));
    endtask

    initial begin
        rst      = 1'b1;
        COFFEE   = 1'b0;
        REFILL_W = 1'b0;
        REFILL_B = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // One full cup, then a DROP during GRIND and one in DONE.
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < T - 6; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        // Drain stock with back-to-back orders until FAULT, then refill both.
        for (int i = 0; i < 17 * (T + 2); i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        // Refill during HEAT, then reset during PUMP.
        for (int i = 0; i < G + 3; i++) step(0, (i == 0), (i == G + 2), 0);
        for (int i = 0; i < H; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
